mac_lut_regs: RTL and testbench
===============================

# mac_lut_regs

Parameterised register front-end for the output-port MAC lookup table, placed on the UDP register ring between the upstream and downstream register blocks. Serves a word-addressed register window that performs handshaked reads and writes of the CAM/LUT and keeps per-source-port hit/miss counters. Counters can wrap or saturate and can be cleared in bulk. A bounded-wait timeout protects every LUT access.

## Interface
Parameters:
- NUM_OUTPUT_QUEUES, 8: width of the oq field; legal range 1..15.
- LUT_DEPTH_BITS, 4: LUT address width.
- NUM_SRC_PORTS, 4: number of per-source-port hit/miss counter pairs; legal range 1..64.
- SRC_PORT_BITS, 2: width of lut_src_port; at least log2(NUM_SRC_PORTS).
- UDP_REG_SRC_WIDTH, 2: width of the ring source tag.
- REG_ADDR_WIDTH, 8: word-address bits decoded locally.
- BLOCK_ADDR, 0: value the tag field must match; the tag field is reg_addr_in[29:REG_ADDR_WIDTH].
- TIMEOUT, 255: maximum number of cycles to wait for rd_ack/wr_ack; legal range 1..65535.

Ports:
- clk  in  1  the block's single clock.
- reset_n  in  1  synchronous, active-low reset.
- reg_req_in / reg_ack_in / reg_rd_wr_L_in  in  1 each  ring request, ack and read/write_L.
- reg_addr_in  in  30  ring word address.
- reg_data_in  in  32  ring data.
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring source tag.
- reg_req_out / reg_ack_out / reg_rd_wr_L_out / reg_addr_out / reg_data_out / reg_src_out  out  same widths as the inputs  registered ring outputs.
- rd_addr  out  LUT_DEPTH_BITS  LUT read address.
- rd_req  out  1  LUT read request.
- rd_oq  in  NUM_OUTPUT_QUEUES  oq field read from the LUT.
- rd_wr_protect  in  1  wr_protect bit read from the LUT.
- rd_mac  in  48  MAC read from the LUT.
- rd_ack  in  1  LUT read acknowledge.
- wr_addr  out  LUT_DEPTH_BITS  LUT write address.
- wr_req  out  1  LUT write request.
- wr_oq  out  NUM_OUTPUT_QUEUES  oq field to write.
- wr_protect  out  1  wr_protect bit to write.
- wr_mac  out  48  MAC to write.
- wr_ack  in  1  LUT write acknowledge.
- lut_hit / lut_miss  in  1 each  single-cycle lookup result pulses.
- lut_src_port  in  SRC_PORT_BITS  source port of the current hit/miss.

## Operation
- Register map (word offset from the block base):
  - 0 PORTS_MAC_HI: bit 31 = protect; bits [NUM_OUTPUT_QUEUES+15:16] = oq; bits [15:0] = mac[47:32].
  - 1 MAC_LO.
  - 2 RD_ADDR: a write triggers a LUT read.
  - 3 WR_ADDR: a write triggers a LUT write.
  - 4 CTRL: bit 0 clear_counters, self-clearing; bit 1 saturate.
  - 5 STATUS: bit 0 rd_timeout, bit 1 wr_timeout; both sticky; any write clears all bits.
  - 6–7 reserved: read 0, writes ignored.
  - 8+2p HITS[p], 9+2p MISSES[p].
- addr_good: local offset < 8+2*NUM_SRC_PORTS.
- Tag miss, or an incoming ack already set: forward all ring fields unchanged.
- States: IDLE, LUT_RD, LUT_WR, DONE.
- IDLE with a tag-hit read: respond directly (req=ack=1, data = register or 0xDEAD_BEEF when !addr_good). Stay in IDLE.
- IDLE with a tag-hit write and addr_good:
  - Load the register.
  - Hold rd_wr_L, addr, data and src.
  - Next state: LUT_RD for offset 2, LUT_WR for offset 3, otherwise DONE.
- IDLE with a tag-hit write and !addr_good: ack immediately with the data unchanged; no state change.
- LUT_RD:
  - rd_req=1 until rd_ack.
  - On rd_ack: load PORTS_MAC_HI = {rd_wr_protect, zeros, rd_oq, rd_mac[47:32]} and MAC_LO = rd_mac[31:0]; go to DONE.
- LUT_WR: wr_req=1 until wr_ack, then go to DONE.
- Timeout: a 16-bit wait counter counts cycles spent in LUT_RD/LUT_WR. When it reaches TIMEOUT without an ack:
  - set the matching STATUS bit;
  - drop the request;
  - go to DONE;
  - for a read, leave PORTS_MAC_HI and MAC_LO unchanged.
- DONE: emit the held transaction with req=ack=1, then return to IDLE.
- Counters (32-bit):
  - lut_hit increments HITS[lut_src_port]; lut_miss increments MISSES[lut_src_port]; both may occur in the same cycle.
  - lut_src_port ≥ NUM_SRC_PORTS: ignored.
  - saturate=0: 0xFFFF_FFFF wraps to 0. saturate=1: counter holds at 0xFFFF_FFFF.
- Priority on any counter: clear_counters > ring write to that counter > increment. An increment that loses is dropped.

## Timing
- All ring outputs are registered.
- Pass-through and local read: response 1 cycle after the request.
- Plain local write: response 2 cycles after the request.
- LUT access: req asserts the cycle after the write; response follows 2 cycles after the ack cycle.
- Timeout with TIMEOUT=N: req is high for exactly N cycles.
- clear_counters: all counters read 0 from the next cycle; the CTRL bit 0 reads back 0.
- One transaction is in flight on the ring at a time. Ring inputs arriving in a non-IDLE state are ignored and not forwarded.
- Reset (reset_n=0 at a clk edge):
  - all outputs 0;
  - all registers and counters 0, CTRL=0, STATUS=0;
  - state IDLE;
  - a LUT access in progress is abandoned immediately (rd_req/wr_req 0 on the next cycle).

## Test plan
- Write MAC_HI=0x8003_0A0B, MAC_LO=0x0C0D_0E0F, then WR_ADDR=5 with wr_ack 3 cycles later:
  - wr_addr=5, wr_mac=0x0A0B_0C0D_0E0F, wr_protect=1, wr_oq=3;
  - wr_req high for 3 cycles;
  - ack response returns data 5.
- Write RD_ADDR=2; LUT returns mac 0x1122_3344_5566, oq=0x05, protect=0:
  - MAC_HI reads 0x0005_1122;
  - MAC_LO reads 0x3344_5566.
- Read of an unmapped offset 40 (NUM_SRC_PORTS=4) returns 0xDEAD_BEEF; a tag-miss request is forwarded unchanged after 1 cycle.
- Counters:
  - 10 hits on port 2 → HITS[2]=10, others 0;
  - with saturate=1 and HITS[1] preloaded to 0xFFFF_FFFF, one more hit leaves it 0xFFFF_FFFF; with saturate=0 it wraps to 0;
  - clear_counters asserted in the same cycle as a hit leaves 0.
- TIMEOUT=8 with wr_ack never asserted: wr_req high for exactly 8 cycles, STATUS=0x2, response delivered; a subsequent STATUS write reads back 0.
- reset_n low during LUT_RD: rd_req=0 and all ring outputs 0 on the next cycle; the next request is serviced normally.

Source files
------------

// File: rtl/mac_lut_regs.sv
// Register-ring front-end for the output-port MAC LUT.
// Handshaked LUT read/write with timeout, plus per-port hit/miss counters.
module mac_lut_regs #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int LUT_DEPTH_BITS    = 4,
    parameter int NUM_SRC_PORTS     = 4,
    parameter int SRC_PORT_BITS     = 2,
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int BLOCK_ADDR        = 0,
    parameter int TIMEOUT           = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [29:0]                  reg_addr_in,
    input  logic [31:0]                  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [29:0]                  reg_addr_out,
    output logic [31:0]                  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
    output logic [LUT_DEPTH_BITS-1:0]    rd_addr,
    output logic                         rd_req,
    input  logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
    input  logic                         rd_wr_protect,
    input  logic [47:0]                  rd_mac,
    input  logic                         rd_ack,
    output logic [LUT_DEPTH_BITS-1:0]    wr_addr,
    output logic                         wr_req,
    output logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
    output logic                         wr_protect,
    output logic [47:0]                  wr_mac,
    input  logic                         wr_ack,
    input  logic                         lut_hit,
    input  logic                         lut_miss,
    input  logic [SRC_PORT_BITS-1:0]     lut_src_port
);

    localparam int NUM_REGS = 8 + 2 * NUM_SRC_PORTS;
    localparam int TAG_W    = 30 - REG_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LUT_RD, LUT_WR, DONE} state_t;

    state_t state_q, state_d;
    logic [15:0] wait_q, wait_d;

    logic                         prot_q, prot_d;
    logic [NUM_OUTPUT_QUEUES-1:0] oq_q, oq_d;
    logic [15:0]                  mach_q, mach_d;
    logic [31:0]                  macl_q, macl_d;
    logic [LUT_DEPTH_BITS-1:0]    rda_q, rda_d;
    logic [LUT_DEPTH_BITS-1:0]    wra_q, wra_d;
    logic                         sat_q, sat_d;
    logic                         rdto_q, rdto_d;
    logic                         wrto_q, wrto_d;
    logic [31:0]                  hits_q [NUM_SRC_PORTS];
    logic [31:0]                  hits_d [NUM_SRC_PORTS];
    logic [31:0]                  miss_q [NUM_SRC_PORTS];
    logic [31:0]                  miss_d [NUM_SRC_PORTS];

    logic                         h_rw_q, h_rw_d;
    logic [29:0]                  h_addr_q, h_addr_d;
    logic [31:0]                  h_data_q, h_data_d;
    logic [UDP_REG_SRC_WIDTH-1:0] h_src_q, h_src_d;

    logic                         req_q, req_d;
    logic                         ack_q, ack_d;
    logic                         rw_q, rw_d;
    logic [29:0]                  addr_q, addr_d;
    logic [31:0]                  data_q, data_d;
    logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;

    logic [31:0] off;
    logic        tag_hit;
    logic        addr_good;
    logic        local_req;
    logic        ring_wr;
    logic        clr;
    logic [31:0] mac_hi_word;
    logic [31:0] rdata;

    function automatic logic [31:0] bump(input logic [31:0] v, input logic sat);
        if (sat && (&v)) return v;
        return v + 32'd1;
    endfunction

    assign off       = 32'(reg_addr_in[REG_ADDR_WIDTH-1:0]);
    assign tag_hit   = reg_addr_in[29:REG_ADDR_WIDTH] == TAG_W'(BLOCK_ADDR);
    assign addr_good = off < 32'(NUM_REGS);
    assign local_req = (state_q == IDLE) && reg_req_in && !reg_ack_in && tag_hit;
    assign ring_wr   = local_req && !reg_rd_wr_L_in && addr_good;
    assign clr       = ring_wr && (off == 32'd4) && reg_data_in[0];

    always_comb begin
        mac_hi_word = '0;
        mac_hi_word[31] = prot_q;
        mac_hi_word[16 +: NUM_OUTPUT_QUEUES] = oq_q;
        mac_hi_word[15:0] = mach_q;
    end

    always_comb begin
        rdata = '0;
        case (off)
            32'd0:   rdata = mac_hi_word;
            32'd1:   rdata = macl_q;
            32'd2:   rdata = 32'(rda_q);
            32'd3:   rdata = 32'(wra_q);
            32'd4:   rdata = {30'b0, sat_q, 1'b0};
            32'd5:   rdata = {30'b0, wrto_q, rdto_q};
            default: rdata = '0;
        endcase
        for (int p = 0; p < NUM_SRC_PORTS; p++) begin
            if (off == 32'(8 + 2 * p)) rdata = hits_q[p];
            if (off == 32'(9 + 2 * p)) rdata = miss_q[p];
        end
    end

    // clear beats ring write beats increment; a losing increment is dropped
    always_comb begin
        hits_d = hits_q;
        miss_d = miss_q;
        for (int p = 0; p < NUM_SRC_PORTS; p++) begin
            if (clr) begin
                hits_d[p] = '0;
                miss_d[p] = '0;
            end else begin
                if (ring_wr && off == 32'(8 + 2 * p))
                    hits_d[p] = reg_data_in;
                else if (lut_hit && 32'(lut_src_port) == 32'(p))
                    hits_d[p] = bump(hits_q[p], sat_q);
                if (ring_wr && off == 32'(9 + 2 * p))
                    miss_d[p] = reg_data_in;
                else if (lut_miss && 32'(lut_src_port) == 32'(p))
                    miss_d[p] = bump(miss_q[p], sat_q);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        prot_d   = prot_q;
        oq_d     = oq_q;
        mach_d   = mach_q;
        macl_d   = macl_q;
        rda_d    = rda_q;
        wra_d    = wra_q;
        sat_d    = sat_q;
        rdto_d   = rdto_q;
        wrto_d   = wrto_q;
        h_rw_d   = h_rw_q;
        h_addr_d = h_addr_q;
        h_data_d = h_data_q;
        h_src_d  = h_src_q;
        req_d    = 1'b0;
        ack_d    = 1'b0;
        rw_d     = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        src_d    = '0;
        case (state_q)
            IDLE: begin
                req_d  = reg_req_in;
                ack_d  = reg_ack_in;
                rw_d   = reg_rd_wr_L_in;
                addr_d = reg_addr_in;
                data_d = reg_data_in;
                src_d  = reg_src_in;
                if (local_req) begin
                    ack_d = 1'b1;
                    if (reg_rd_wr_L_in) begin
                        data_d = addr_good ? rdata : 32'hDEAD_BEEF;
                    end else if (addr_good) begin
                        req_d    = 1'b0;
                        ack_d    = 1'b0;
                        rw_d     = 1'b0;
                        addr_d   = '0;
                        data_d   = '0;
                        src_d    = '0;
                        h_rw_d   = reg_rd_wr_L_in;
                        h_addr_d = reg_addr_in;
                        h_data_d = reg_data_in;
                        h_src_d  = reg_src_in;
                        wait_d   = '0;
                        if (off == 32'd2)      state_d = LUT_RD;
                        else if (off == 32'd3) state_d = LUT_WR;
                        else                   state_d = DONE;
                        case (off)
                            32'd0: begin
                                prot_d = reg_data_in[31];
                                oq_d   = reg_data_in[16 +: NUM_OUTPUT_QUEUES];
                                mach_d = reg_data_in[15:0];
                            end
                            32'd1: macl_d = reg_data_in;
                            32'd2: rda_d  = reg_data_in[LUT_DEPTH_BITS-1:0];
                            32'd3: wra_d  = reg_data_in[LUT_DEPTH_BITS-1:0];
                            32'd4: sat_d  = reg_data_in[1];
                            32'd5: begin
                                rdto_d = 1'b0;
                                wrto_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            LUT_RD: begin
                if (rd_ack) begin
                    prot_d  = rd_wr_protect;
                    oq_d    = rd_oq;
                    mach_d  = rd_mac[47:32];
                    macl_d  = rd_mac[31:0];
                    state_d = DONE;
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    rdto_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            LUT_WR: begin
                if (wr_ack) begin
                    state_d = DONE;
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    wrto_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            DONE: begin
                req_d   = 1'b1;
                ack_d   = 1'b1;
                rw_d    = h_rw_q;
                addr_d  = h_addr_q;
                data_d  = h_data_q;
                src_d   = h_src_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            prot_q   <= 1'b0;
            oq_q     <= '0;
            mach_q   <= '0;
            macl_q   <= '0;
            rda_q    <= '0;
            wra_q    <= '0;
            sat_q    <= 1'b0;
            rdto_q   <= 1'b0;
            wrto_q   <= 1'b0;
            h_rw_q   <= 1'b0;
            h_addr_q <= '0;
            h_data_q <= '0;
            h_src_q  <= '0;
            req_q    <= 1'b0;
            ack_q    <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            src_q    <= '0;
            for (int p = 0; p < NUM_SRC_PORTS; p++) begin
                hits_q[p] <= '0;
                miss_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            prot_q   <= prot_d;
            oq_q     <= oq_d;
            mach_q   <= mach_d;
            macl_q   <= macl_d;
            rda_q    <= rda_d;
            wra_q    <= wra_d;
            sat_q    <= sat_d;
            rdto_q   <= rdto_d;
            wrto_q   <= wrto_d;
            h_rw_q   <= h_rw_d;
            h_addr_q <= h_addr_d;
            h_data_q <= h_data_d;
            h_src_q  <= h_src_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            for (int p = 0; p < NUM_SRC_PORTS; p++) begin
                hits_q[p] <= hits_d[p];
                miss_q[p] <= miss_d[p];
            end
        end
    end

    assign reg_req_out     = req_q;
    assign reg_ack_out     = ack_q;
    assign reg_rd_wr_L_out = rw_q;
    assign reg_addr_out    = addr_q;
    assign reg_data_out    = data_q;
    assign reg_src_out     = src_q;

    assign rd_addr    = rda_q;
    assign rd_req     = (state_q == LUT_RD);
    assign wr_addr    = wra_q;
    assign wr_req     = (state_q == LUT_WR);
    assign wr_oq      = oq_q;
    assign wr_protect = prot_q;
    assign wr_mac     = {mach_q, macl_q};

endmodule

// File: tb/tb_mac_lut_regs.sv
// Directed bench for mac_lut_regs: ring access, LUT handshake,
// timeout, counters and reset abandonment.
module tb_mac_lut_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [29:0] reg_addr_in;
    logic [31:0] reg_data_in;
    logic [1:0]  reg_src_in;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [29:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;
    logic [3:0]  rd_addr, wr_addr;
    logic        rd_req, wr_req;
    logic [7:0]  rd_oq, wr_oq;
    logic        rd_wr_protect, wr_protect;
    logic [47:0] rd_mac, wr_mac;
    logic        rd_ack, wr_ack;
    logic        lut_hit, lut_miss;
    logic [1:0]  lut_src_port;

    int tests = 0;
    int fails = 0;

    mac_lut_regs #(
        .NUM_OUTPUT_QUEUES(8), .LUT_DEPTH_BITS(4), .NUM_SRC_PORTS(4),
        .SRC_PORT_BITS(2), .UDP_REG_SRC_WIDTH(2), .REG_ADDR_WIDTH(8),
        .BLOCK_ADDR(0), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
        .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
        .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
        .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
        .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_oq(rd_oq),
        .rd_wr_protect(rd_wr_protect), .rd_mac(rd_mac), .rd_ack(rd_ack),
        .wr_addr(wr_addr), .wr_req(wr_req), .wr_oq(wr_oq),
        .wr_protect(wr_protect), .wr_mac(wr_mac), .wr_ack(wr_ack),
        .lut_hit(lut_hit), .lut_miss(lut_miss), .lut_src_port(lut_src_port)
    );

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] ring_out();
        return 80'({reg_req_out, reg_ack_out, reg_rd_wr_L_out,
                    reg_src_out, reg_addr_out, reg_data_out});
    endfunction

    // called at a negedge; request is sampled on the following posedge
    task automatic ring_req(input logic rw, input logic [29:0] a,
                            input logic [31:0] d, input logic [1:0] s);
        reg_req_in     = 1'b1;
        reg_rd_wr_L_in = rw;
        reg_addr_in    = a;
        reg_data_in    = d;
        reg_src_in     = s;
        @(negedge clk);
        reg_req_in     = 1'b0;
        reg_rd_wr_L_in = 1'b0;
        reg_addr_in    = '0;
        reg_data_in    = '0;
        reg_src_in     = '0;
    endtask

    task automatic rd(input string tag, input logic [29:0] a,
                      input logic [31:0] exp);
        ring_req(1'b1, a, 32'h0, 2'd1);
        chk(tag, ring_out(), 80'({3'b111, 2'd1, a, exp}));
    endtask

    task automatic wr(input string tag, input logic [29:0] a,
                      input logic [31:0] d);
        ring_req(1'b0, a, d, 2'd2);
        @(negedge clk);
        chk(tag, ring_out(), 80'({3'b110, 2'd2, a, d}));
    endtask

    task automatic lut_wait(input string tag, input bit is_rd,
                            input int ack_at, input int exp_cycles,
                            input logic [29:0] a, input logic [31:0] d);
        int cnt = 0;
        bit ended = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(is_rd ? rd_req : wr_req)) begin
                ended = 1;
                break;
            end
            cnt++;
            if (cnt == ack_at) begin
                if (is_rd) rd_ack = 1'b1;
                else wr_ack = 1'b1;
            end
            @(negedge clk);
            rd_ack = 1'b0;
            wr_ack = 1'b0;
        end
        chk({tag, "_ended"}, 80'(ended), 80'd1);
        chk({tag, "_cycles"}, 80'(cnt), 80'(exp_cycles));
        @(negedge clk);
        chk({tag, "_resp"}, ring_out(), 80'({3'b110, 2'd2, a, d}));
    endtask

    task automatic pulse_hit(input logic [1:0] p);
        lut_hit = 1'b1;
        lut_src_port = p;
        @(negedge clk);
        lut_hit = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
        rd_oq = '0; rd_wr_protect = 1'b0; rd_mac = '0;
        rd_ack = 1'b0; wr_ack = 1'b0;
        lut_hit = 1'b0; lut_miss = 1'b0; lut_src_port = '0;
        repeat (3) @(negedge clk);
        chk("rst_ring", ring_out(), 80'd0);
        chk("rst_lut", 80'({rd_req, wr_req, wr_protect, wr_oq, wr_addr, rd_addr}), 80'd0);
        chk("rst_mac", 80'(wr_mac), 80'd0);
        reset_n = 1'b1;
        @(negedge clk);

        wr("wr_machi", 30'd0, 32'h8003_0A0B);
        wr("wr_maclo", 30'd1, 32'h0C0D_0E0F);
        ring_req(1'b0, 30'd3, 32'd5, 2'd2);
        chk("lut_wr_addr", 80'(wr_addr), 80'd5);
        chk("lut_wr_mac", 80'(wr_mac), 80'h0A0B_0C0D_0E0F);
        chk("lut_wr_prot_oq", 80'({wr_protect, wr_oq}), 80'({1'b1, 8'h03}));
        lut_wait("lut_wr", 1'b0, 3, 3, 30'd3, 32'd5);

        rd_mac = 48'h1122_3344_5566;
        rd_oq = 8'h05;
        rd_wr_protect = 1'b0;
        ring_req(1'b0, 30'd2, 32'd2, 2'd2);
        chk("lut_rd_addr", 80'(rd_addr), 80'd2);
        lut_wait("lut_rd", 1'b1, 1, 1, 30'd2, 32'd2);
        rd_mac = '0;
        rd_oq = '0;
        rd("rd_machi", 30'd0, 32'h0005_1122);
        rd("rd_maclo", 30'd1, 32'h3344_5566);
        rd("rd_unmapped", 30'd40, 32'hDEAD_BEEF);
        rd("rd_reserved", 30'd6, 32'h0);

        ring_req(1'b0, 30'h105, 32'h1234_5678, 2'd2);
        chk("tag_miss_fwd", ring_out(), 80'({3'b100, 2'd2, 30'h105, 32'h1234_5678}));
        rd("after_miss_maclo", 30'd1, 32'h3344_5566);

        for (int i = 0; i < 10; i++) pulse_hit(2'd2);
        rd("hits2", 30'd12, 32'd10);
        rd("hits0", 30'd8, 32'd0);
        rd("miss2", 30'd13, 32'd0);
        lut_hit = 1'b1; lut_miss = 1'b1; lut_src_port = 2'd3;
        repeat (2) @(negedge clk);
        lut_hit = 1'b0; lut_miss = 1'b0;
        rd("hits3", 30'd14, 32'd2);
        rd("miss3", 30'd15, 32'd2);

        wr("wr_sat", 30'd4, 32'd2);
        rd("rd_ctrl_sat", 30'd4, 32'd2);
        wr("wr_hits1", 30'd10, 32'hFFFF_FFFF);
        pulse_hit(2'd1);
        rd("hits1_sat", 30'd10, 32'hFFFF_FFFF);
        wr("wr_nosat", 30'd4, 32'd0);
        pulse_hit(2'd1);
        rd("hits1_wrap", 30'd10, 32'd0);

        lut_hit = 1'b1; lut_src_port = 2'd0;
        ring_req(1'b0, 30'd8, 32'h100, 2'd2);
        lut_hit = 1'b0;
        @(negedge clk);
        chk("prio_wr_ack", ring_out(), 80'({3'b110, 2'd2, 30'd8, 32'h100}));
        rd("prio_hits0", 30'd8, 32'h100);

        lut_hit = 1'b1; lut_src_port = 2'd2;
        ring_req(1'b0, 30'd4, 32'd1, 2'd2);
        lut_hit = 1'b0;
        @(negedge clk);
        chk("clr_ack", ring_out(), 80'({3'b110, 2'd2, 30'd4, 32'd1}));
        rd("clr_hits2", 30'd12, 32'd0);
        rd("clr_miss3", 30'd15, 32'd0);
        rd("clr_ctrl", 30'd4, 32'd0);

        ring_req(1'b0, 30'd3, 32'd7, 2'd2);
        lut_wait("wr_to", 1'b0, 0, 8, 30'd3, 32'd7);
        rd("status_to", 30'd5, 32'd2);
        wr("wr_status", 30'd5, 32'd0);
        rd("status_clr", 30'd5, 32'd0);

        ring_req(1'b0, 30'd2, 32'd1, 2'd2);
        chk("rst_mid_rdreq", 80'(rd_req), 80'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", 80'({rd_req, wr_req}), 80'd0);
        chk("rst_mid_ring", ring_out(), 80'd0);
        reset_n = 1'b1;
        @(negedge clk);
        rd("post_rst_machi", 30'd0, 32'd0);
        wr("post_rst_wr", 30'd1, 32'hCAFE_F00D);
        rd("post_rst_rd", 30'd1, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
